ads_init_sequencer: RTL and testbench

Frame-level command sequencer for the ADS131A0x SPI link. It runs in the SCLK domain and picks the 32-bit command word shifted out on every SPI frame. After reset it walks the ADC through the power-up handshake (SYNC/READY, UNLOCK, WREG ADC_ENA, WAKEUP, LOCK) and checks each echoed response. It then hands the link to a single user command port, and sends NULL (0x0000) frames for plain data reads. It sits beside the SPI master: the master owns CS/SCLK timing, and this block owns MOSI content and MISO interpretation.

---
 rtl/ads_init_sequencer.sv | 161 ++++++++++++++++
 tb/tb_ads_init_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ads_init_sequencer.sv
// Frame-level command sequencer for the ADS131A0x SPI link: walks the power-up
// handshake, verifies each echoed word, then serves a single user command port.
module ads_init_sequencer #(
  parameter int WORD_BITS = 32,
  parameter int MAX_RETRY = 15
) (
  input  logic                 SPI_SCLK_Temp,
  input  logic                 reset_n,
  input  logic                 cs_n,
  input  logic                 miso_bit,
  output logic                 mosi_bit,
  input  logic                 user_req,
  input  logic [15:0]          user_cmd,
  output logic                 user_ack,
  output logic [15:0]          user_rsp,
  output logic                 user_rsp_valid,
  output logic [WORD_BITS-1:0] rsp_word,
  output logic                 rsp_valid,
  output logic                 init_done,
  output logic                 init_error,
  output logic [3:0]           seq_state,
  output logic [7:0]           retry_count
);
  localparam int CNT_W = $clog2(WORD_BITS);
  localparam int PAD_W = WORD_BITS - 16;
  localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  typedef enum logic [3:0] {
    SYNC_CMD = 4'd0, SYNC_VFY = 4'd1,
    UNL_CMD  = 4'd2, UNL_VFY  = 4'd3,
    ENA_CMD  = 4'd4, ENA_VFY  = 4'd5,
    WAK_CMD  = 4'd6, WAK_VFY  = 4'd7,
    LCK_CMD  = 4'd8, LCK_VFY  = 4'd9,
    RUN      = 4'd10, ERROR   = 4'd11
  } state_t;

  state_t state, state_nxt, pass_st, fail_st;
  logic [CNT_W-1:0]     bit_cnt;
  logic [WORD_BITS-1:0] tx_sr, cur_cmd, cmd_nxt, resp_full;
  logic [WORD_BITS-2:0] rx_sr;
  logic [7:0]           retry_nxt;
  logic                 frame_end, vfy, accept, done_set, err_set, rsp_pend;

  function automatic logic [15:0] step_cmd(input state_t st);
    case (st)
      UNL_CMD: step_cmd = 16'h0655;
      ENA_CMD: step_cmd = 16'h4F0F;
      WAK_CMD: step_cmd = 16'h0033;
      LCK_CMD: step_cmd = 16'h0555;
      default: step_cmd = 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] step_echo(input state_t st);
    case (st)
      SYNC_VFY: step_echo = 16'hFF04;
      UNL_VFY:  step_echo = 16'h0655;
      ENA_VFY:  step_echo = 16'h2F0F;
      WAK_VFY:  step_echo = 16'h0033;
      LCK_VFY:  step_echo = 16'h0555;
      default:  step_echo = 16'h0000;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign frame_end = !cs_n && (bit_cnt == LAST_BIT);
  assign resp_full = {rx_sr, miso_bit};
  assign mosi_bit  = tx_sr[WORD_BITS-1];
  assign seq_state = state;

  always_comb begin
    state_nxt = state;
    pass_st   = state;
    fail_st   = state;
    retry_nxt = retry_count;
    vfy       = 1'b0;
    accept    = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    case (state)
      SYNC_CMD: state_nxt = SYNC_VFY;
      UNL_CMD:  state_nxt = UNL_VFY;
      ENA_CMD:  state_nxt = ENA_VFY;
      WAK_CMD:  state_nxt = WAK_VFY;
      LCK_CMD:  state_nxt = LCK_VFY;
      SYNC_VFY: begin vfy = 1'b1; pass_st = UNL_CMD; fail_st = SYNC_CMD; end
      UNL_VFY:  begin vfy = 1'b1; pass_st = ENA_CMD; fail_st = UNL_CMD;  end
      ENA_VFY:  begin vfy = 1'b1; pass_st = WAK_CMD; fail_st = ENA_CMD;  end
      WAK_VFY:  begin vfy = 1'b1; pass_st = LCK_CMD; fail_st = WAK_CMD;  end
      LCK_VFY:  begin vfy = 1'b1; pass_st = RUN;     fail_st = LCK_CMD;  end
      RUN:      accept = user_req;
      default:  ;
    endcase
    if (vfy) begin
      if (resp_full[WORD_BITS-1 -: 16] == step_echo(state)) begin
        state_nxt = pass_st;
        retry_nxt = 8'd0;
        done_set  = (pass_st == RUN);
      end else if (retry_count < RETRY_LIM) begin
        state_nxt = fail_st;
        retry_nxt = sat_inc(retry_count);
      end else begin
        state_nxt = ERROR;
        err_set   = 1'b1;
      end
    end
    cmd_nxt = accept ? {user_cmd, {PAD_W{1'b0}}} : {step_cmd(state_nxt), {PAD_W{1'b0}}};
  end

  // cur_cmd remembers the word loaded at the last frame end so an aborted frame re-sends it
  always_ff @(posedge SPI_SCLK_Temp) begin
    if (!reset_n) begin
      state          <= SYNC_CMD;
      bit_cnt        <= '0;
      tx_sr          <= '0;
      cur_cmd        <= '0;
      rx_sr          <= '0;
      rsp_word       <= '0;
      rsp_valid      <= 1'b0;
      user_ack       <= 1'b0;
      user_rsp       <= 16'h0000;
      user_rsp_valid <= 1'b0;
      init_done      <= 1'b0;
      init_error     <= 1'b0;
      retry_count    <= 8'd0;
      rsp_pend       <= 1'b0;
    end else begin
      rsp_valid      <= 1'b0;
      user_ack       <= 1'b0;
      user_rsp_valid <= 1'b0;
      if (cs_n) begin
        bit_cnt <= '0;
        tx_sr   <= cur_cmd;
      end else if (frame_end) begin
        bit_cnt     <= '0;
        rsp_word    <= resp_full;
        rsp_valid   <= 1'b1;
        tx_sr       <= cmd_nxt;
        cur_cmd     <= cmd_nxt;
        state       <= state_nxt;
        retry_count <= retry_nxt;
        if (done_set) init_done  <= 1'b1;
        if (err_set)  init_error <= 1'b1;
        if (rsp_pend) begin
          user_rsp       <= resp_full[WORD_BITS-1 -: 16];
          user_rsp_valid <= 1'b1;
        end
        rsp_pend <= accept;
        user_ack <= accept;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
        tx_sr   <= {tx_sr[WORD_BITS-2:0], 1'b0};
        rx_sr   <= {rx_sr[WORD_BITS-3:0], miso_bit};
      end
    end
  end
endmodule

// File: tb/tb_ads_init_sequencer.sv
// Bench for ads_init_sequencer: frame-level ADC stimulus, vector table, directed
// corner sequences and a randomized run against a step-indexed reference model.
module tb_ads_init_sequencer;
  localparam int W = 32;
  localparam logic [15:0] CMD_T  [5] = '{16'h0000, 16'h0655, 16'h4F0F, 16'h0033, 16'h0555};
  localparam logic [15:0] ECHO_T [5] = '{16'hFF04, 16'h0655, 16'h2F0F, 16'h0033, 16'h0555};

  logic clk = 1'b0;
  logic reset_n, cs_n, miso_bit, mosi_bit, user_req, user_ack, user_rsp_valid;
  logic rsp_valid, init_done, init_error;
  logic [15:0] user_cmd, user_rsp;
  logic [W-1:0] rsp_word;
  logic [3:0] seq_state;
  logic [7:0] retry_count;

  ads_init_sequencer #(.WORD_BITS(W), .MAX_RETRY(15)) dut (
    .SPI_SCLK_Temp(clk), .reset_n(reset_n), .cs_n(cs_n), .miso_bit(miso_bit),
    .mosi_bit(mosi_bit), .user_req(user_req), .user_cmd(user_cmd), .user_ack(user_ack),
    .user_rsp(user_rsp), .user_rsp_valid(user_rsp_valid), .rsp_word(rsp_word),
    .rsp_valid(rsp_valid), .init_done(init_done), .init_error(init_error),
    .seq_state(seq_state), .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] miso_hi;
    logic [15:0] mosi_hi;
    logic [7:0]  retry;
    logic        done;
  } vec_t;
  vec_t tbl [13];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, ack_n = 0, urv_n = 0, rv_n = 0, ack_cyc = 0, urv_cyc = 0;
  logic [W-1:0] f_mosi;

  int m_step, m_retry;
  bit m_vfy, m_done, m_err, m_pend;
  logic [15:0] m_next;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (user_ack) begin ack_cyc = cyc; ack_n++; user_req = 1'b0; end
    if (user_rsp_valid) begin urv_cyc = cyc; urv_n++; end
    if (rsp_valid) rv_n++;
  endtask

  task automatic run_frame(input logic [W-1:0] miso_word, input int req_at, input logic [15:0] cmd);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) begin
      if (i == req_at) begin user_req = 1'b1; user_cmd = cmd; end
      cs_n     = 1'b0;
      miso_bit = miso_word[W-1-i];
      m[W-1-i] = mosi_bit;
      tick();
    end
    f_mosi = m;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; cs_n = 1'b1; user_req = 1'b0; miso_bit = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic model_reset();
    m_step = 0; m_vfy = 1'b0; m_retry = 0; m_done = 1'b0; m_err = 1'b0;
    m_pend = 1'b0; m_next = 16'h0000;
  endtask

  // Steps 0..4 are the handshake, 5 is normal operation, 6 is the error sink
  task automatic model_end(input logic [15:0] rhi, input bit req, input logic [15:0] cmd,
                           output bit ea, output bit eu);
    ea = 1'b0; eu = 1'b0;
    if (m_step == 5) begin
      eu = m_pend; m_pend = req; ea = req; m_next = req ? cmd : 16'h0000;
    end else if (m_step == 6) begin
      m_next = 16'h0000;
    end else if (!m_vfy) begin
      m_vfy = 1'b1; m_next = 16'h0000;
    end else if (rhi == ECHO_T[m_step]) begin
      m_step++; m_vfy = 1'b0; m_retry = 0;
      if (m_step == 5) begin m_done = 1'b1; m_next = 16'h0000; end
      else m_next = CMD_T[m_step];
    end else if (m_retry < 15) begin
      m_retry++; m_vfy = 1'b0; m_next = CMD_T[m_step];
    end else begin
      m_step = 6; m_err = 1'b1; m_next = 16'h0000;
    end
  endtask

  initial begin
    logic [W-1:0] w;
    int a0, u0, r0, t_ack, req_at;
    bit ea, eu;
    logic [15:0] ucmd, hi;

    tbl[0]  = '{16'h0000, 16'h0000, 8'd0, 1'b0};
    tbl[1]  = '{16'hFF04, 16'h0000, 8'd0, 1'b0};
    tbl[2]  = '{16'h0000, 16'h0655, 8'd0, 1'b0};
    tbl[3]  = '{16'h0000, 16'h0000, 8'd1, 1'b0};
    tbl[4]  = '{16'h0000, 16'h0655, 8'd1, 1'b0};
    tbl[5]  = '{16'h0655, 16'h0000, 8'd0, 1'b0};
    tbl[6]  = '{16'h0000, 16'h4F0F, 8'd0, 1'b0};
    tbl[7]  = '{16'h2F0F, 16'h0000, 8'd0, 1'b0};
    tbl[8]  = '{16'h0000, 16'h0033, 8'd0, 1'b0};
    tbl[9]  = '{16'h0033, 16'h0000, 8'd0, 1'b0};
    tbl[10] = '{16'h0000, 16'h0555, 8'd0, 1'b0};
    tbl[11] = '{16'h0555, 16'h0000, 8'd0, 1'b1};
    tbl[12] = '{16'h0000, 16'h0000, 8'd0, 1'b1};

    user_cmd = 16'h0000;
    do_reset();
    chk("rst mosi", 32'(mosi_bit), 0);
    chk("rst rsp_word", rsp_word, 0);
    chk("rst pulses", {29'd0, rsp_valid, user_ack, user_rsp_valid}, 0);
    chk("rst user_rsp", 32'(user_rsp), 0);
    chk("rst flags", {30'd0, init_done, init_error}, 0);
    chk("rst retry", 32'(retry_count), 0);

    // Handshake with one UNLOCK retry
    for (int k = 0; k < 13; k++) begin
      w  = {tbl[k].miso_hi, 16'($urandom)};
      r0 = rv_n;
      run_frame(w, -1, 16'h0000);
      chk($sformatf("tbl%0d mosi", k), f_mosi, {tbl[k].mosi_hi, 16'h0000});
      chk($sformatf("tbl%0d rsp_word", k), rsp_word, w);
      chk($sformatf("tbl%0d rsp_valid", k), rv_n - r0, 1);
      chk($sformatf("tbl%0d retry", k), 32'(retry_count), 32'(tbl[k].retry));
      chk($sformatf("tbl%0d done", k), 32'(init_done), 32'(tbl[k].done));
    end

    // Single user access
    a0 = ack_n; u0 = urv_n;
    run_frame({16'h1234, 16'h5678}, 10, 16'h2100);
    chk("usr ack count", ack_n - a0, 1);
    chk("usr ack at frame end", ack_cyc, cyc);
    t_ack = ack_cyc;
    run_frame({16'h2230, 16'hBEEF}, -1, 16'h0000);
    chk("usr mosi", f_mosi, 32'h2100_0000);
    chk("usr rsp_valid", 32'(user_rsp_valid), 1);
    chk("usr rsp", 32'(user_rsp), 32'h2230);
    chk("usr ack->rsp latency", urv_cyc - t_ack, W);
    chk("usr single ack", ack_n - a0, 1);

    // Back-to-back requests
    a0 = ack_n; u0 = urv_n;
    run_frame({16'h0BAD, 16'h0000}, 5, 16'hA1A1);
    run_frame({16'h1111, 16'h0001}, 3, 16'hB2B2);
    chk("b2b mosi A", f_mosi, 32'hA1A1_0000);
    chk("b2b rsp A", 32'(user_rsp), 32'h1111);
    run_frame({16'h2222, 16'h0002}, -1, 16'h0000);
    chk("b2b mosi B", f_mosi, 32'hB2B2_0000);
    chk("b2b rsp B", 32'(user_rsp), 32'h2222);
    chk("b2b acks", ack_n - a0, 2);
    chk("b2b rsps", urv_n - u0, 2);

    // cs_n abort at bit 10 of a carrying frame
    run_frame({16'h0F0F, 16'h0000}, 0, 16'hC3C3);
    r0 = rv_n; u0 = urv_n;
    for (int i = 0; i < 10; i++) begin
      cs_n = 1'b0; miso_bit = 1'($urandom); tick();
    end
    cs_n = 1'b1; tick();
    chk("abort rsp_valid", rv_n - r0, 0);
    chk("abort reload msb", 32'(mosi_bit), 1);
    run_frame({16'h3333, 16'h4444}, -1, 16'h0000);
    chk("abort resend", f_mosi, 32'hC3C3_0000);
    chk("abort rsp", 32'(user_rsp), 32'h3333);
    chk("abort rsp count", urv_n - u0, 1);
    chk("abort rv count", rv_n - r0, 1);

    // Reset in the middle of a frame
    for (int i = 0; i < 12; i++) begin
      cs_n = 1'b0; miso_bit = 1'b1; tick();
    end
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("mrst done", 32'(init_done), 0);
    chk("mrst mosi", 32'(mosi_bit), 0);
    run_frame({16'h0000, 16'h0000}, -1, 16'h0000);
    chk("mrst f0 mosi", f_mosi, 0);
    run_frame({16'hFF04, 16'h0000}, -1, 16'h0000);
    chk("mrst f1 mosi", f_mosi, 0);
    run_frame({16'h0000, 16'h0000}, -1, 16'h0000);
    chk("mrst f2 mosi", f_mosi, 32'h0655_0000);

    // SYNC never acknowledged: error after 16 failed verifies
    do_reset();
    for (int k = 0; k < 16; k++) begin
      run_frame(32'h0000_0000, -1, 16'h0000);
      run_frame(32'h0000_0000, -1, 16'h0000);
      chk($sformatf("err retry%0d", k), 32'(retry_count), (k < 15) ? k + 1 : 15);
      chk($sformatf("err flag%0d", k), 32'(init_error), (k == 15) ? 1 : 0);
    end
    a0 = ack_n;
    user_cmd = 16'h2100; user_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      run_frame({16'hFF04, 16'h0000}, -1, 16'h0000);
      chk($sformatf("err null%0d", k), f_mosi, 0);
    end
    chk("err no ack", ack_n - a0, 0);
    chk("err sticky", {30'd0, init_done, init_error}, 1);
    user_req = 1'b0;

    // Randomized runs against the reference model
    for (int it = 0; it < 3; it++) begin
      do_reset();
      model_reset();
      for (int f = 0; f < 60; f++) begin
        if (m_vfy && m_step < 5 && $urandom_range(0, 3) != 0) hi = ECHO_T[m_step];
        else hi = 16'($urandom);
        w = {hi, 16'($urandom)};
        req_at = -1;
        ucmd = 16'($urandom);
        if (m_step == 5 && $urandom_range(0, 1) == 1) req_at = int'($urandom_range(0, 31));
        a0 = ack_n; u0 = urv_n;
        run_frame(w, req_at, ucmd);
        chk($sformatf("rnd%0d.%0d mosi", it, f), f_mosi, {m_next, 16'h0000});
        model_end(hi, req_at >= 0, ucmd, ea, eu);
        chk($sformatf("rnd%0d.%0d flags", it, f), {29'd0, init_done, init_error, 1'b0},
            {29'd0, m_done, m_err, 1'b0});
        chk($sformatf("rnd%0d.%0d retry", it, f), 32'(retry_count), m_retry);
        chk($sformatf("rnd%0d.%0d ack", it, f), ack_n - a0, ea ? 1 : 0);
        chk($sformatf("rnd%0d.%0d urv", it, f), urv_n - u0, eu ? 1 : 0);
        if (eu) chk($sformatf("rnd%0d.%0d user_rsp", it, f), 32'(user_rsp), 32'(hi));
      end
      user_req = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
